// File: rtl/rdram_uart_dump_pkg.sv
// Shared constants and state encoding for the RAM read-back dump path.
// The UART RAM loader uses the same base address and word count.
package rdram_uart_dump_pkg;

    localparam logic [31:0] RAM_BASE_ADDR = 32'h1000_0000;
    localparam int unsigned LOAD_WORDS    = 270;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_TX_LOAD,
        ST_TX_WAIT,
        ST_NEXT,
        ST_DONE
    } dump_state_e;

    // Byte idx of a word, MSB first, matching the loader's assembly order.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0: b = word[31:24];
            2'd1: b = word[23:16];
            2'd2: b = word[15:8];
            2'd3: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rdram_uart_dump_byte_sel.sv
// Holds the word being dumped and the index of the byte currently on the wire;
// presents that byte MSB first.
module rdram_uart_dump_byte_sel
    import rdram_uart_dump_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        adv_i,
    output logic [7:0]  byte_o,
    output logic [1:0]  idx_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;

    // NOTE: defaults first so every path assigns word_d/idx_d and no latch is inferred.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (load_i) begin
            word_d = word_i;
            idx_d  = 2'd0;
        end else if (adv_i) begin
            idx_d  = idx_q + 2'd1;
        end
    end

    // NOTE: this is a single register, not a memory array, so resetting it is cheap and keeps X out of tx_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
            idx_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign byte_o = word_byte(word_q, idx_q);
    assign idx_o  = idx_q;

endmodule

// File: rtl/rdram_uart_dump.sv
// Reads WORD_COUNT words from RAM starting at BASE_ADDR and streams each one
// to the UART transmitter as four bytes, MSB first.
module rdram_uart_dump
    import rdram_uart_dump_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = RAM_BASE_ADDR,
    parameter int unsigned WORD_COUNT = LOAD_WORDS,
    parameter int unsigned CNT_W      = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             debug_en_i,
    input  logic             start_i,
    output logic             r_req_o,
    output logic [31:0]      r_addr_o,
    input  logic             r_ack_i,
    input  logic [31:0]      r_data_i,
    output logic             tx_start_o,
    output logic [7:0]       tx_data_o,
    input  logic             tx_busy_i,
    input  logic             tx_done_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    dump_state_e      state_q;
    logic             r_req_q;
    logic [31:0]      r_addr_q;
    logic             tx_start_q;
    logic [7:0]       tx_data_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] word_cnt_q;

    logic             abort;
    logic             word_load;
    logic             byte_adv;
    logic [7:0]       cur_byte;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] word_cnt_inc;

    assign abort        = (state_q != ST_IDLE) && !debug_en_i;
    assign word_load    = (state_q == ST_RD_WAIT) && r_ack_i && !abort;
    assign byte_adv     = (state_q == ST_TX_WAIT) && tx_done_i && (byte_idx != 2'd3) && !abort;
    assign word_cnt_inc = word_cnt_q + CNT_W'(1);

    rdram_uart_dump_byte_sel u_byte_sel (
        .clk    (clk),
        .rst    (rst),
        .load_i (word_load),
        .word_i (r_data_i),
        .adv_i  (byte_adv),
        .byte_o (cur_byte),
        .idx_o  (byte_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            r_req_q    <= 1'b0;
            r_addr_q   <= BASE_ADDR;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            word_cnt_q <= '0;
        end else if (abort) begin
            state_q    <= ST_IDLE;
            r_req_q    <= 1'b0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q    <= ST_RD_REQ;
                        r_req_q    <= 1'b1;
                        r_addr_q   <= BASE_ADDR;
                        word_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_RD_REQ: state_q <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    // An idle transmitter gets the first byte straight from the read data.
                    if (r_ack_i) begin
                        r_req_q <= 1'b0;
                        if (!tx_busy_i) begin
                            tx_start_q <= 1'b1;
                            tx_data_q  <= word_byte(r_data_i, 2'd0);
                            state_q    <= ST_TX_WAIT;
                        end else begin
                            state_q    <= ST_TX_LOAD;
                        end
                    end
                end
                ST_TX_LOAD: begin
                    if (!tx_busy_i) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= cur_byte;
                        state_q    <= ST_TX_WAIT;
                    end
                end
                ST_TX_WAIT: begin
                    if (tx_done_i) begin
                        state_q <= (byte_idx == 2'd3) ? ST_NEXT : ST_TX_LOAD;
                    end
                end
                ST_NEXT: begin
                    word_cnt_q <= word_cnt_inc;
                    if (word_cnt_inc == CNT_W'(WORD_COUNT)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        r_addr_q <= r_addr_q + 32'd4;
                        r_req_q  <= 1'b1;
                        state_q  <= ST_RD_REQ;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign r_req_o    = r_req_q;
    assign r_addr_o   = r_addr_q;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_rdram_uart_dump.sv
// Directed bench: a 2-word dump instance for the protocol cases and a default
// 270-word instance for the full image dump; RAM and UART are played by tasks.
module tb_rdram_uart_dump;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk;
    logic        rst;
    logic        debug_en;
    logic        start_a, start_b;
    logic        r_ack;
    logic [31:0] r_data;
    logic        tx_busy, tx_done;
    logic        sel;

    logic        a_r_req, a_tx_start, a_busy, a_done;
    logic [31:0] a_r_addr;
    logic [7:0]  a_tx_data;
    logic [8:0]  a_cnt;
    logic        b_r_req, b_tx_start, b_busy, b_done;
    logic [31:0] b_r_addr;
    logic [7:0]  b_tx_data;
    logic [8:0]  b_cnt;

    logic        cur_r_req, cur_tx_start, cur_busy, cur_done;
    logic [31:0] cur_r_addr;
    logic [7:0]  cur_tx_data;
    logic [8:0]  cur_cnt;

    int checks = 0;
    int errors = 0;
    int byte_count = 0;

    rdram_uart_dump #(.WORD_COUNT(2)) dut_a (
        .clk(clk), .rst(rst), .debug_en_i(debug_en), .start_i(start_a),
        .r_req_o(a_r_req), .r_addr_o(a_r_addr), .r_ack_i(r_ack), .r_data_i(r_data),
        .tx_start_o(a_tx_start), .tx_data_o(a_tx_data), .tx_busy_i(tx_busy), .tx_done_i(tx_done),
        .busy_o(a_busy), .done_o(a_done), .word_cnt_o(a_cnt)
    );

    rdram_uart_dump dut_b (
        .clk(clk), .rst(rst), .debug_en_i(debug_en), .start_i(start_b),
        .r_req_o(b_r_req), .r_addr_o(b_r_addr), .r_ack_i(r_ack), .r_data_i(r_data),
        .tx_start_o(b_tx_start), .tx_data_o(b_tx_data), .tx_busy_i(tx_busy), .tx_done_i(tx_done),
        .busy_o(b_busy), .done_o(b_done), .word_cnt_o(b_cnt)
    );

    assign cur_r_req    = sel ? b_r_req    : a_r_req;
    assign cur_r_addr   = sel ? b_r_addr   : a_r_addr;
    assign cur_tx_start = sel ? b_tx_start : a_tx_start;
    assign cur_tx_data  = sel ? b_tx_data  : a_tx_data;
    assign cur_busy     = sel ? b_busy     : a_busy;
    assign cur_done     = sel ? b_done     : a_done;
    assign cur_cnt      = sel ? b_cnt      : a_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic abort_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "bounded wait expired");
    endtask

    function automatic logic [31:0] pat(input int n);
        logic [7:0] b;
        b = 8'(4 * n);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, " r_req"},    32'(cur_r_req),    32'd0);
        check({tag, " r_addr"},   cur_r_addr,        BASE);
        check({tag, " tx_start"}, 32'(cur_tx_start), 32'd0);
        check({tag, " tx_data"},  32'(cur_tx_data),  32'd0);
        check({tag, " busy"},     32'(cur_busy),     32'd0);
        check({tag, " done"},     32'(cur_done),     32'd0);
        check({tag, " word_cnt"}, 32'(cur_cnt),      32'd0);
    endtask

    task automatic pulse_start(input string tag);
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        check({tag, " start r_req"},  32'(cur_r_req), 32'd1);
        check({tag, " start busy"},   32'(cur_busy),  32'd1);
        check({tag, " start addr"},   cur_r_addr,     BASE);
        check({tag, " start cnt"},    32'(cur_cnt),   32'd0);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (cur_r_req !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " r_req seen"}, 32'(cur_r_req), 32'd1);
        if (cur_r_req !== 1'b1) abort_run();
    endtask

    task automatic wait_tx(input string tag);
        int n = 0;
        while (cur_tx_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " tx_start seen"}, 32'(cur_tx_start), 32'd1);
        if (cur_tx_start !== 1'b1) abort_run();
    endtask

    // RAM side: answers a pending read after 'delay' cycles (delay >= 1).
    task automatic serve_read(input logic [31:0] addr, input logic [31:0] data,
                              input int delay, input bit spurious, input string tag);
        wait_req(tag);
        check({tag, " r_addr"}, cur_r_addr, addr);
        for (int k = 0; k < delay; k++) begin
            check({tag, " r_req held"}, 32'(cur_r_req), 32'd1);
            check({tag, " no tx_start in read"}, 32'(cur_tx_start), 32'd0);
            tx_done = (spurious && k == 3);
            @(negedge clk);
        end
        tx_done = 1'b0;
        r_ack   = 1'b1;
        r_data  = data;
        @(negedge clk);
        r_ack   = 1'b0;
        r_data  = 32'h0;
        check({tag, " r_req dropped"}, 32'(cur_r_req), 32'd0);
    endtask

    // UART side: takes one byte, stays busy a few cycles, then signals done.
    task automatic serve_byte(input logic [7:0] exp, input string tag);
        wait_tx(tag);
        check({tag, " tx_data"}, 32'(cur_tx_data), 32'(exp));
        byte_count++;
        tx_busy = 1'b1;
        @(negedge clk);
        check({tag, " tx_start width"}, 32'(cur_tx_start), 32'd0);
        for (int k = 0; k < 2; k++) begin
            check({tag, " tx_data stable"}, 32'(cur_tx_data), 32'(exp));
            @(negedge clk);
        end
        tx_busy = 1'b0;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic serve_word(input logic [31:0] w, input string tag);
        for (int i = 0; i < 4; i++) serve_byte(8'(w >> (24 - 8 * i)), tag);
    endtask

    task automatic finish_check(input string tag, input int cnt, input logic [31:0] last_addr);
        check({tag, " no early done"}, 32'(cur_done), 32'd0);
        @(negedge clk);
        check({tag, " done pulse"},    32'(cur_done), 32'd1);
        check({tag, " busy cleared"},  32'(cur_busy), 32'd0);
        check({tag, " word_cnt"},      32'(cur_cnt),  32'(cnt));
        check({tag, " last addr"},     cur_r_addr,    last_addr);
        @(negedge clk);
        check({tag, " done width"},    32'(cur_done), 32'd0);
        check({tag, " cnt kept"},      32'(cur_cnt),  32'(cnt));
    endtask

    task automatic run_dump2(input string tag, input logic [31:0] w0, input logic [31:0] w1);
        pulse_start(tag);
        serve_read(BASE, w0, 1, 1'b0, tag);
        check({tag, " ack to tx_start"}, 32'(cur_tx_start), 32'd1);
        serve_word(w0, tag);
        serve_read(BASE + 32'd4, w1, 1, 1'b0, tag);
        serve_word(w1, tag);
        finish_check(tag, 2, BASE + 32'd4);
    endtask

    initial begin
        rst = 1'b0; debug_en = 1'b1; start_a = 1'b0; start_b = 1'b0;
        r_ack = 1'b0; r_data = 32'h0; tx_busy = 1'b0; tx_done = 1'b0; sel = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);

        // Plain two-word dump.
        run_dump2("t1", 32'hDEAD_BEEF, 32'h0123_4567);

        // Slow RAM with a stray tx_done, then a transmitter busy for 50 cycles.
        pulse_start("t23");
        tx_busy = 1'b1;
        serve_read(BASE, 32'hDEAD_BEEF, 10, 1'b1, "t3");
        check("t3 busy kept", 32'(cur_busy), 32'd1);
        for (int k = 0; k < 50; k++) begin
            check("t2 held by tx_busy", 32'(cur_tx_start), 32'd0);
            @(negedge clk);
        end
        tx_busy = 1'b0;
        serve_word(32'hDEAD_BEEF, "t2");
        serve_read(BASE + 32'd4, 32'h0123_4567, 1, 1'b0, "t2");
        serve_word(32'h0123_4567, "t2");
        finish_check("t2", 2, BASE + 32'd4);

        // Abort after the second byte of word 0, then restart.
        pulse_start("t4");
        serve_read(BASE, 32'hDEAD_BEEF, 1, 1'b0, "t4");
        serve_byte(8'hDE, "t4");
        serve_byte(8'hAD, "t4");
        debug_en = 1'b0;
        @(negedge clk);
        check("t4 abort busy",  32'(cur_busy),  32'd0);
        check("t4 abort r_req", 32'(cur_r_req), 32'd0);
        for (int k = 0; k < 8; k++) begin
            check("t4 no tx_start", 32'(cur_tx_start), 32'd0);
            check("t4 no done",     32'(cur_done),     32'd0);
            check("t4 no r_req",    32'(cur_r_req),    32'd0);
            @(negedge clk);
        end
        debug_en = 1'b1;
        @(negedge clk);
        run_dump2("t4r", 32'hCAFE_F00D, 32'h89AB_CDEF);

        // Start ignored mid-dump, then reset mid-dump.
        pulse_start("t5");
        serve_read(BASE, 32'hDEAD_BEEF, 1, 1'b0, "t5");
        serve_byte(8'hDE, "t5");
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        serve_byte(8'hAD, "t5");
        serve_byte(8'hBE, "t5");
        serve_byte(8'hEF, "t5");
        wait_req("t5");
        check("t5 word1 addr", cur_r_addr,     BASE + 32'd4);
        check("t5 word1 cnt",  32'(cur_cnt),   32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_values("t5 async reset");
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t5 quiet r_req",    32'(cur_r_req),    32'd0);
            check("t5 quiet tx_start", 32'(cur_tx_start), 32'd0);
            check("t5 quiet busy",     32'(cur_busy),     32'd0);
            @(negedge clk);
        end
        run_dump2("t5r", 32'hDEAD_BEEF, 32'h0123_4567);

        // Full default-size dump on the second instance.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sel = 1'b1;
        byte_count = 0;
        pulse_start("t6");
        for (int n = 0; n < 270; n++) begin
            serve_read(BASE + 32'(4 * n), pat(n), 1, 1'b0, "t6");
            serve_word(pat(n), "t6");
        end
        check("t6 byte count", 32'(byte_count), 32'd1080);
        finish_check("t6", 270, 32'h1000_0434);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
